// File: rtl/axi_w_feeder_pkg.sv
// Shared types and constants for the AXI W-channel feeder and its output buffer.
package axi_w_feeder_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int SKID_DEPTH = 4;
    // Wide enough to hold 0..SKID_DEPTH inclusive
    localparam int CRED_W     = $clog2(SKID_DEPTH + 1);

endpackage

// File: rtl/fifo_read_if.sv
// Read side of a FIFO whose data is registered and valid the cycle after read.
interface FIFO_READ #(
    parameter int DATA_WIDTH = 64
);
    logic                  read;
    logic                  empty;
    logic [DATA_WIDTH-1:0] data;

    modport master (output read, input empty, input data);
    modport slave  (input read, output empty, output data);
endinterface

// File: rtl/w_skid_buf.sv
// Small circular buffer holding W beats (data, strb, last) between FIFO read and AXI handshake.
module w_skid_buf
    import axi_w_feeder_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int STRB_W     = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic [STRB_W-1:0]     push_strb,
    input  logic                  push_last,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic [STRB_W-1:0]     head_strb,
    output logic                  head_last,
    output logic [CRED_W-1:0]     occupancy
);
    localparam int PTR_W = $clog2(SKID_DEPTH);

    logic [DATA_WIDTH-1:0] data_mem [SKID_DEPTH];
    logic [STRB_W-1:0]     strb_mem [SKID_DEPTH];
    logic                  last_mem [SKID_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [CRED_W-1:0]     count_q;

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_q] <= push_data;
            strb_mem[wr_ptr_q] <= push_strb;
            last_mem[wr_ptr_q] <= push_last;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CRED_W'(1);
                2'b01:   count_q <= count_q - CRED_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_data = data_mem[rd_ptr_q];
    assign head_strb = strb_mem[rd_ptr_q];
    assign head_last = last_mem[rd_ptr_q];
    assign occupancy = count_q;

endmodule

// File: rtl/axi_w_feeder.sv
// AXI4 W-channel feeder: streams cmd_len+1 beats from a registered-read FIFO through a 4-entry buffer.
// Optional macro REDMA_PARTIAL_STRB_EN adds cmd_last_bytes for a partial strobe on the final beat.
module axi_w_feeder
    import axi_w_feeder_pkg::*;
#(
    parameter int  DATA_WIDTH = 64,
    parameter int  MAX_LEN    = 256,
    localparam int STRB_W     = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    FIFO_READ.master              fifo_rd,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [7:0]            cmd_len,
`ifdef REDMA_PARTIAL_STRB_EN
    input  logic [((STRB_W > 1) ? $clog2(STRB_W) : 1)-1:0] cmd_last_bytes,
`endif
    output logic [DATA_WIDTH-1:0] w_data,
    output logic [STRB_W-1:0]     w_strb,
    output logic                  w_last,
    output logic                  w_valid,
    input  logic                  w_ready,
    output logic                  done
);
    localparam int BEAT_W = 9;

    state_e            state_q;
    logic [BEAT_W-1:0] last_idx_q;
    logic [BEAT_W-1:0] req_left_q;
    logic [BEAT_W-1:0] push_idx_q;
    logic              inflight_q;
    logic              done_q;

    logic [BEAT_W-1:0] len_eff;
    logic [CRED_W-1:0] occ;
    logic [CRED_W-1:0] credits;
    logic              rd_d;
    logic              push;
    logic              push_last;
    logic [STRB_W-1:0] push_strb;
    logic              pop;

    // Bursts longer than MAX_LEN are clipped to MAX_LEN beats.
    always_comb begin
        len_eff = {1'b0, cmd_len};
        if (len_eff >= BEAT_W'(MAX_LEN)) len_eff = BEAT_W'(MAX_LEN - 1);
    end

    // A read is only issued when a buffer slot is guaranteed for its data.
    assign credits   = CRED_W'(SKID_DEPTH) - occ - CRED_W'(inflight_q);
    assign rd_d      = rstn && (state_q == ST_RUN) && !fifo_rd.empty
                       && (req_left_q != '0) && (credits != '0);
    assign fifo_rd.read = rd_d;

    assign push      = inflight_q;
    assign push_last = (push_idx_q == last_idx_q);
    assign pop       = w_valid && w_ready;
    assign cmd_ready = (state_q == ST_IDLE);
    assign done      = done_q;

`ifdef REDMA_PARTIAL_STRB_EN
    localparam int LB_W = (STRB_W > 1) ? $clog2(STRB_W) : 1;
    logic [LB_W-1:0] last_bytes_q;

    function automatic logic [STRB_W-1:0] last_strb(input logic [LB_W-1:0] nbytes);
        last_strb = '1;
        if (nbytes != '0) begin
            for (int i = 0; i < STRB_W; i++) last_strb[i] = (i < int'(nbytes));
        end
    endfunction

    assign push_strb = push_last ? last_strb(last_bytes_q) : '1;
`else
    assign push_strb = '1;
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            last_idx_q <= '0;
            req_left_q <= '0;
            push_idx_q <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
`ifdef REDMA_PARTIAL_STRB_EN
            last_bytes_q <= '0;
`endif
        end else begin
            inflight_q <= rd_d;
            done_q     <= pop && w_last;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        state_q    <= ST_RUN;
                        last_idx_q <= len_eff;
                        req_left_q <= len_eff + BEAT_W'(1);
                        push_idx_q <= '0;
`ifdef REDMA_PARTIAL_STRB_EN
                        last_bytes_q <= cmd_last_bytes;
`endif
                    end
                end
                ST_RUN: begin
                    if (rd_d) req_left_q <= req_left_q - BEAT_W'(1);
                    if (push) push_idx_q <= push_idx_q + BEAT_W'(1);
                    if (pop && w_last) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    w_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .STRB_W     (STRB_W)
    ) u_skid (
        .clk       (clk),
        .rstn      (rstn),
        .push      (push),
        .push_data (fifo_rd.data),
        .push_strb (push_strb),
        .push_last (push_last),
        .pop       (pop),
        .head_data (w_data),
        .head_strb (w_strb),
        .head_last (w_last),
        .occupancy (occ)
    );

    assign w_valid = (occ != '0);

endmodule

// File: tb/tb_axi_w_feeder.sv
// Scoreboard bench for axi_w_feeder: FIFO model, W monitor, latency/stability/reset checks.
module tb_axi_w_feeder;
    localparam int DW = 64;
    localparam int SW = DW / 8;
`ifdef REDMA_PARTIAL_STRB_EN
    localparam bit PARTIAL = 1'b1;
`else
    localparam bit PARTIAL = 1'b0;
`endif

    typedef struct packed {
        logic [DW-1:0] d;
        logic [SW-1:0] s;
        logic          l;
    } beat_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    FIFO_READ #(.DATA_WIDTH(DW)) fifo_if ();

    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [7:0]    cmd_len = '0;
`ifdef REDMA_PARTIAL_STRB_EN
    logic [2:0]    cmd_last_bytes = '0;
`endif
    logic [DW-1:0] w_data;
    logic [SW-1:0] w_strb;
    logic          w_last;
    logic          w_valid;
    logic          w_ready = 1'b1;
    logic          done;

    axi_w_feeder #(.DATA_WIDTH(DW), .MAX_LEN(256)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .fifo_rd   (fifo_if),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_len   (cmd_len),
`ifdef REDMA_PARTIAL_STRB_EN
        .cmd_last_bytes (cmd_last_bytes),
`endif
        .w_data    (w_data),
        .w_strb    (w_strb),
        .w_last    (w_last),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .done      (done)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [SW-1:0] exp_strb(input bit last, input int lb);
        if (PARTIAL && last && lb != 0) return (SW'(1) << lb) - SW'(1);
        return '1;
    endfunction

    // FIFO model: registered data, read pops the head.
    logic [DW-1:0] fq[$];
    int rd_viol = 0;
    always @(posedge clk) begin
        if (fifo_if.read) begin
            if (fifo_if.empty || fq.size() == 0) rd_viol++;
            else fifo_if.data <= fq.pop_front();
        end
    end
    always begin
        fifo_if.empty = (fq.size() == 0);
        @(posedge clk);
        #2;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit wr_toggle = 1'b0;
    always @(posedge clk) begin
        #1;
        w_ready = wr_toggle ? ~w_ready : 1'b1;
    end

    // W monitor / scoreboard
    beat_t exq[$];
    beat_t prev_beat, e;
    bit    prev_stall = 0, prev_last_hs = 0;
    int    beats_seen = 0, burst_idx = 0, first_cyc = 0, last_cyc = 0;
    int    done_cyc = 0, done_cnt = 0, rd_cnt = 0, pop_cnt = 0, prot_err = 0;

    always @(negedge clk) begin
        if (!rstn) begin
            prev_stall = 0; prev_last_hs = 0; burst_idx = 0; rd_cnt = 0; pop_cnt = 0;
        end else begin
            if (done || prev_last_hs) begin
                chk("done_pulse", done, prev_last_hs);
                if (done) begin done_cnt++; done_cyc = cyc; end
            end
            if (fifo_if.read) begin
                rd_cnt++;
                if (cmd_ready) prot_err++;
                if (rd_cnt - pop_cnt > 4) prot_err++;
            end
            if (prev_stall) chk("w_hold", {w_valid, w_data, w_strb, w_last}, {1'b1, prev_beat});
            prev_last_hs = 0;
            if (w_valid && w_ready) begin
                if (exq.size() == 0) chk("extra_beat", 1, 0);
                else begin
                    e = exq.pop_front();
                    chk("w_data", w_data, e.d);
                    chk("w_strb", w_strb, e.s);
                    chk("w_last", w_last, e.l);
                end
                if (burst_idx == 0) first_cyc = cyc;
                last_cyc = cyc;
                burst_idx++;
                beats_seen++;
                pop_cnt++;
                if (w_last) burst_idx = 0;
                prev_last_hs = w_last;
            end
            prev_stall = w_valid && !w_ready;
            prev_beat  = {w_data, w_strb, w_last};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input int n, input int start, input int len, input int lb);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.d = {$urandom, $urandom};
            b.l = (start + i == len);
            b.s = exp_strb(b.l, lb);
            fq.push_back(b.d);
            exq.push_back(b);
        end
    endtask

    task automatic send_cmd(input int len, input int lb, output int t_hs);
        cmd_valid = 1'b1;
        cmd_len   = 8'(len);
`ifdef REDMA_PARTIAL_STRB_EN
        cmd_last_bytes = 3'(lb);
`endif
        t_hs = -1;
        for (int k = 0; k < 100 && t_hs < 0; k++) begin
            @(negedge clk);
            if (cmd_ready) t_hs = cyc;
            tick();
        end
        cmd_valid = 1'b0;
        chk("cmd_accept", t_hs >= 0, 1);
    endtask

    task automatic wait_done(input int budget);
        int d0 = done_cnt;
        for (int k = 0; k < budget && done_cnt == d0; k++) tick();
        chk("done_timeout", done_cnt > d0, 1);
    endtask

    initial begin
        int t, b0, d0;
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, b0, d0;
        // Reset values, during and after reset
        tick(); tick();
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_w_valid", w_valid, 0);
        tick();
        rstn = 1'b1;
        @(negedge clk);
        chk("post_rst_w_valid", w_valid, 0);
        chk("post_rst_w_last", w_last, 0);
        chk("post_rst_read", fifo_if.read, 0);
        chk("post_rst_done", done, 0);
        chk("post_rst_cmd_ready", cmd_ready, 1);
        tick();

        // 4-beat burst latency
        feed(4, 0, 3, 0);
        send_cmd(3, 0, t);
        wait_done(50);
        chk("lat_first", first_cyc - t, 3);
        chk("lat_last", last_cyc - t, 6);
        chk("lat_done", done_cyc - t, 7);
        tick();

        // 8-beat burst with w_ready toggling
        b0 = beats_seen;
        wr_toggle = 1'b1;
        feed(8, 0, 7, 0);
        send_cmd(7, 0, t);
        wait_done(200);
        wr_toggle = 1'b0;
        chk("toggle_beats", beats_seen - b0, 8);
        tick(); tick();

        // 256-beat burst, no bubbles
        b0 = beats_seen;
        feed(256, 0, 255, 0);
        send_cmd(255, 0, t);
        wait_done(600);
        chk("long_beats", beats_seen - b0, 256);
        chk("long_first", first_cyc - t, 3);
        chk("long_span", last_cyc - first_cyc, 255);
        tick();

        // FIFO runs dry mid-burst
        b0 = beats_seen;
        feed(3, 0, 7, 0);
        send_cmd(7, 0, t);
        for (int k = 0; k < 50 && beats_seen < b0 + 3; k++) tick();
        for (int k = 0; k < 5; k++) tick();
        @(negedge clk);
        chk("dry_w_valid", w_valid, 0);
        chk("dry_beats", beats_seen - b0, 3);
        tick();
        feed(5, 3, 7, 0);
        wait_done(100);
        chk("dry_total", beats_seen - b0, 8);
        tick();

        // Reset at beat 2 of 8
        b0 = beats_seen;
        d0 = done_cnt;
        feed(8, 0, 7, 0);
        send_cmd(7, 0, t);
        for (int k = 0; k < 50 && beats_seen < b0 + 2; k++) tick();
        rstn = 1'b0;
        exq.delete();
        fq.delete();
        tick();
        rstn = 1'b1;
        @(negedge clk);
        chk("midrst_w_valid", w_valid, 0);
        chk("midrst_cmd_ready", cmd_ready, 1);
        chk("midrst_done", done, 0);
        for (int k = 0; k < 6; k++) tick();
        chk("midrst_no_done", done_cnt - d0, 0);

        // New burst after reset, partial strobe on the last beat when enabled
        b0 = beats_seen;
        feed(2, 0, 1, 3);
        send_cmd(1, 3, t);
        wait_done(50);
        chk("after_rst_beats", beats_seen - b0, 2);
        tick(); tick();

        chk("read_when_empty", rd_viol, 0);
        chk("protocol", prot_err, 0);
        chk("sb_left", exq.size(), 0);
        chk("fifo_left", fq.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
